// File: rtl/rom_arb_pkg.sv
// Shared types and default sizes for the boot-ROM arbiter.
// Build option: ROM_ARB_SETTLE_EN enables the post-reset settle delay.
package rom_arb_pkg;

    localparam int DEF_ADDR_WIDTH    = 9;
    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_SETTLE_CYCLES = 16;

    typedef enum logic [2:0] {
        SETTLE = 3'd0,
        IDLE   = 3'd1,
        ADDR   = 3'd2,
        FETCH  = 3'd3,
        ACK    = 3'd4
    } state_t;

    // Round-robin pick: on a tie the port that did not win last time goes next.
    function automatic logic pick_port(input logic req0, input logic req1,
                                       input logic last_grant);
        return (req0 && req1) ? ~last_grant : req1;
    endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// Requester-side bundle of the boot-ROM arbiter (both read ports plus ready).
// Build option: ROM_ARB_SETTLE_EN (affects when ready rises, not this bundle).
interface rom_arbiter_if #(
    parameter int ADDR_WIDTH = rom_arb_pkg::DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = rom_arb_pkg::DEF_DATA_WIDTH
);
    // reqN is a level held until ackN; addrN is only sampled on the grant edge;
    // ackN is a single-cycle pulse qualifying rdata; nothing is granted while ready is low.
    logic                  req0;
    logic                  req1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic                  ack0;
    logic                  ack1;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  ready;

    modport master (output req0, req1, addr0, addr1,
                    input  ack0, ack1, rdata, ready);

    modport slave  (input  req0, req1, addr0, addr1,
                    output ack0, ack1, rdata, ready);

endinterface

// File: rtl/rom_settle_timer.sv
// Post-reset settle counter: done rises once SETTLE_CYCLES-1 clocks have elapsed and then holds.
// Only instantiated when ROM_ARB_SETTLE_EN is defined.
module rom_settle_timer #(
    parameter int SETTLE_CYCLES = rom_arb_pkg::DEF_SETTLE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    output logic done
);
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (!done) begin
            count <= count + CW'(1);
        end
    end

    assign done = (count == LAST);

endmodule

// File: rtl/rom_arbiter.sv
// Two-port round-robin front end for the synchronous-read boot ROM.
// Build option: ROM_ARB_SETTLE_EN adds the post-reset settle delay before the first read.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    rom_arbiter_if.slave          bus,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output state_t                state
);
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 65535) begin : g_bad_settle
        $error("rom_arbiter: SETTLE_CYCLES must be within 1..65535");
    end

    logic settle_done;

`ifdef ROM_ARB_SETTLE_EN
    localparam state_t RESET_STATE = SETTLE;

    rom_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle (
        .clk   (clk),
        .reset (reset),
        .done  (settle_done)
    );
`else
    localparam state_t RESET_STATE = IDLE;

    assign settle_done = 1'b1;
`endif

    state_t                state_next;
    logic                  grant;
    logic                  grant_next;
    logic                  last_grant;
    logic                  load_addr;
    logic                  capture;
    logic                  ready_q;
    logic                  ready_next;
    logic                  ack0_q;
    logic                  ack1_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [ADDR_WIDTH-1:0] addr_sel;

    always_comb begin
        state_next = state;
        grant_next = grant;
        load_addr  = 1'b0;
        capture    = 1'b0;
        // ready only stays low while still counting out the settle delay
        ready_next = !(state == SETTLE && !settle_done);
        case (state)
            SETTLE: if (settle_done) state_next = IDLE;
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    grant_next = pick_port(bus.req0, bus.req1, last_grant);
                    load_addr  = 1'b1;
                    state_next = ADDR;
                end
            end
            ADDR:  state_next = FETCH;
            FETCH: begin
                capture    = 1'b1;
                state_next = ACK;
            end
            ACK:     state_next = IDLE;
            default: state_next = RESET_STATE;
        endcase
        addr_sel = grant_next ? bus.addr1 : bus.addr0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RESET_STATE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            rom_addr   <= '0;
            rdata_q    <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state   <= state_next;
            grant   <= grant_next;
            ready_q <= ready_next;
            ack0_q  <= capture && !grant;
            ack1_q  <= capture && grant;
            if (load_addr) rom_addr <= addr_sel;
            if (capture) begin
                rdata_q    <= rom_data;
                last_grant <= grant;
            end
        end
    end

    assign bus.ack0  = ack0_q;
    assign bus.ack1  = ack1_q;
    assign bus.rdata = rdata_q;
    assign bus.ready = ready_q;

endmodule
